rx_frame_sched: RTL and testbench
=================================

Name: rx_frame_sched

Overview:
- Frame-level scheduler in front of the rx cipher datapath.
- Arbitrates two AXI-Stream input channels round-robin, one complete frame (sof..eof) per grant.
- Before each frame, loads the granted channel's PRBS seed into the PRBS generator with a reload pulse, then streams the frame through a one-deep registered output stage.
- Sits between the link-side stream sources and the rx datapath's s_axis input; the seed and reload outputs drive the PRBS seed/reload inputs.

Parameters:
- C_DATA_WIDTH, 32, stream data width.
- C_MAX_FRAME_LEN, 1024, maximum words per frame before over-length abort (>=2).
- C_LEN_WIDTH, 16, width of the word counter and of the frame counters.

Ports:
- s_axi_aclk  in  1  clock
- s_axi_aresetn  in  1  async active-low reset
- i_enable  in  1  scheduler enable (register-driven)
- i_seed0  in  32  PRBS seed for channel 0
- i_seed1  in  32  PRBS seed for channel 1
- i_err_clr  in  1  one-cycle pulse, clears sticky error flags
- s0_axis_tvalid / s0_axis_tready / s0_axis_sof / s0_axis_eof  in/out/in/in  1 each  channel 0 stream handshake and framing
- s0_axis_tdata  in  C_DATA_WIDTH  channel 0 data
- s1_axis_*  same as s0  channel 1 stream
- m_axis_tready  in  1  datapath ready
- m_axis_tvalid  out  1  output valid
- m_axis_tdata  out  C_DATA_WIDTH  output data
- m_axis_sof / m_axis_eof  out  1  output framing
- o_prbs_seed  out  32  seed to the PRBS generator
- o_prbs_reload  out  1  one-cycle seed reload pulse
- o_grant  out  1  channel currently/last granted
- o_busy  out  1  high outside IDLE
- o_frame_cnt0 / o_frame_cnt1  out  C_LEN_WIDTH  completed-frame counters, wrap at 2^C_LEN_WIDTH
- o_err_orphan  out  1  sticky: non-sof word received while idle
- o_err_overlen  out  1  sticky: frame exceeded C_MAX_FRAME_LEN

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer = 1 (channel 0 wins the first tie), counters 0.
- Request definition: channel n requests when sn_tvalid && sn_sof.
- IDLE:
  - if i_enable and a request exists, go to RELOAD. Grant the sole requester; if both request, grant the channel != last grant. Latch o_grant and drive o_prbs_seed = i_seedN.
  - any channel presenting tvalid && !sof is drained (tready=1 for that cycle), the word is discarded, and o_err_orphan is set.
  - if i_enable=0, all s*_tready = 0.
- RELOAD: o_prbs_reload=1 for exactly 1 cycle; s*_tready=0; go to XFER next cycle. o_prbs_seed stays stable from RELOAD until the next grant.
- XFER:
  - only the granted channel has tready; the other channel's tready=0.
  - Granted tready = !m_axis_tvalid || m_axis_tready.
  - On an accepted word: the output register loads tdata, sof and eof; m_axis_tvalid=1 next cycle (latency 1). The word counter increments.
  - m_axis_tvalid clears when m_axis_tready=1 and no new word is accepted.
  - Holding m_axis_tready=0 holds the output register stable; no data loss or duplication.
  - Accepted word with eof: increment o_frame_cntN (wraps), flip the round-robin pointer, go to DRAIN.
  - Accepted word is word number C_MAX_FRAME_LEN and eof=0: force m_axis_eof=1 on it, set o_err_overlen, increment the frame counter, go to FLUSH.
  - sof asserted on a non-first word is ignored (passed as sof=0).
- FLUSH: granted tready=1; words are discarded without output until an accepted eof, then go to DRAIN.
- DRAIN: wait until the output register is empty (m_axis_tvalid=0 or accepted this cycle), then go to IDLE. The next frame's RELOAD never overlaps an undelivered word of the previous frame.
- i_enable falling mid-frame: the current frame completes normally; the scheduler stays IDLE afterwards.
- i_err_clr clears both sticky flags. If a set condition occurs in the same cycle, set wins.
- Async reset mid-frame: immediate return to reset values; the partial frame is abandoned.

Decomposition:
- Shared package rx_pkg:
  - state enum: IDLE, RELOAD, XFER, FLUSH, DRAIN
  - channel-index constants
  - default C_MAX_FRAME_LEN
- One sub-module, rx_axis_outreg: the one-deep registered valid/ready output stage carrying data+sof+eof. It is reusable by the rx datapath's back-pressure fix.

Test Plan:
- Single frame on ch0, 4 words 0x11..0x44, seed0=0xDEADBEEF, m_tready=1:
  - o_prbs_reload pulses once with o_prbs_seed=0xDEADBEEF.
  - Output words appear 1 cycle after acceptance, sof on 0x11, eof on 0x44.
  - o_frame_cnt0=1.
- Both channels present 3-word frames continuously:
  - grants alternate 0,1,0,1.
  - each frame is preceded by a reload with the matching seed.
  - no interleaving of words between frames.
- m_tready toggled 1-0-0-1 during a 6-word frame: output sequence identical to input, with no drops or duplicates.
- Frame of C_MAX_FRAME_LEN+3 words (param 8) on ch1:
  - 8 words are output, with eof forced on word 8.
  - o_err_overlen=1; 3 words are flushed.
  - the next frame proceeds normally.
  - i_err_clr clears the flag.
- Ch0 word with sof=0 while IDLE: the word is consumed, there is no output, o_err_orphan=1. A following valid sof frame is scheduled normally.
- Reset asserted at word 2 of a frame: all outputs 0 immediately, including tready. After release, ch0 wins the first tie.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared constants for the rx frame scheduler: FSM state codes, channel indices
// and the default frame-length limit.
package rx_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RELOAD = 3'd1;
    localparam logic [2:0] ST_XFER   = 3'd2;
    localparam logic [2:0] ST_FLUSH  = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    localparam int unsigned DEF_MAX_FRAME_LEN = 1024;

endpackage

// File: rtl/rx_axis_outreg.sv
// One-deep registered valid/ready stage carrying data plus sof/eof framing.
// Accepts a new word whenever the register is empty or being drained this cycle.
module rx_axis_outreg #(
    parameter int unsigned C_DATA_WIDTH = 32
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [C_DATA_WIDTH-1:0] in_data,
    input  logic                    in_sof,
    input  logic                    in_eof,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [C_DATA_WIDTH-1:0] out_data,
    output logic                    out_sof,
    output logic                    out_eof
);

    assign in_ready = ~out_valid | out_ready;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_sof   <= in_sof;
            out_eof   <= in_eof;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rx_frame_sched.sv
// Round-robin frame scheduler in front of the rx cipher datapath: grants one
// whole frame per channel, reloads that channel's PRBS seed, then streams it.
//
// state  | meaning
// IDLE   | wait for a sof request; drain orphan words
// RELOAD | one-cycle PRBS seed reload pulse, inputs stalled
// XFER   | stream granted channel through the output register
// FLUSH  | over-length frame: discard words up to eof
// DRAIN  | wait for the last word to leave the output register
module rx_frame_sched
    import rx_pkg::*;
#(
    parameter int unsigned C_DATA_WIDTH    = 32,
    parameter int unsigned C_MAX_FRAME_LEN = DEF_MAX_FRAME_LEN,
    parameter int unsigned C_LEN_WIDTH     = 16
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    input  logic                    i_enable,
    input  logic [31:0]             i_seed0,
    input  logic [31:0]             i_seed1,
    input  logic                    i_err_clr,
    input  logic                    s0_axis_tvalid,
    output logic                    s0_axis_tready,
    input  logic                    s0_axis_sof,
    input  logic                    s0_axis_eof,
    input  logic [C_DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                    s1_axis_tvalid,
    output logic                    s1_axis_tready,
    input  logic                    s1_axis_sof,
    input  logic                    s1_axis_eof,
    input  logic [C_DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tvalid,
    output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_sof,
    output logic                    m_axis_eof,
    output logic [31:0]             o_prbs_seed,
    output logic                    o_prbs_reload,
    output logic                    o_grant,
    output logic                    o_busy,
    output logic [C_LEN_WIDTH-1:0]  o_frame_cnt0,
    output logic [C_LEN_WIDTH-1:0]  o_frame_cnt1,
    output logic                    o_err_orphan,
    output logic                    o_err_overlen
);

    localparam logic [C_LEN_WIDTH-1:0] LAST_IDX = C_LEN_WIDTH'(C_MAX_FRAME_LEN - 1);

    logic [2:0]              state;
    logic                    rr_last;
    logic [C_LEN_WIDTH-1:0]  word_cnt;
    logic                    req0, req1, pick, start, orph0, orph1;
    logic                    sel_valid, sel_sof, sel_eof;
    logic [C_DATA_WIDTH-1:0] sel_data;
    logic                    or_in_ready, last_word, xfer_fire, frame_done;
    logic                    overlen_hit, flush_end, out_empty, g_rdy;

    assign req0  = s0_axis_tvalid & s0_axis_sof;
    assign req1  = s1_axis_tvalid & s1_axis_sof;
    assign pick  = (req0 & req1) ? ~rr_last : req1;
    assign start = (state == ST_IDLE) & i_enable & (req0 | req1);
    assign orph0 = (state == ST_IDLE) & i_enable & s0_axis_tvalid & ~s0_axis_sof;
    assign orph1 = (state == ST_IDLE) & i_enable & s1_axis_tvalid & ~s1_axis_sof;

    assign sel_valid = (o_grant == CH1) ? s1_axis_tvalid : s0_axis_tvalid;
    assign sel_sof   = (o_grant == CH1) ? s1_axis_sof    : s0_axis_sof;
    assign sel_eof   = (o_grant == CH1) ? s1_axis_eof    : s0_axis_eof;
    assign sel_data  = (o_grant == CH1) ? s1_axis_tdata  : s0_axis_tdata;

    assign last_word   = (word_cnt == LAST_IDX);
    assign xfer_fire   = (state == ST_XFER) & sel_valid & or_in_ready;
    assign frame_done  = xfer_fire & (sel_eof | last_word);
    assign overlen_hit = xfer_fire & last_word & ~sel_eof;
    assign flush_end   = (state == ST_FLUSH) & sel_valid & sel_eof;
    assign out_empty   = ~m_axis_tvalid | m_axis_tready;
    assign g_rdy       = (state == ST_XFER) ? or_in_ready : (state == ST_FLUSH);

    // Gated by reset so the combinational orphan drain cannot show ready during reset.
    assign s0_axis_tready = s_axi_aresetn & (orph0 | ((o_grant == CH0) & g_rdy));
    assign s1_axis_tready = s_axi_aresetn & (orph1 | ((o_grant == CH1) & g_rdy));

    assign o_prbs_reload = (state == ST_RELOAD);
    assign o_busy        = (state != ST_IDLE);

    rx_axis_outreg #(
        .C_DATA_WIDTH (C_DATA_WIDTH)
    ) u_outreg (
        .s_axi_aclk    (s_axi_aclk),
        .s_axi_aresetn (s_axi_aresetn),
        .in_valid      ((state == ST_XFER) & sel_valid),
        .in_ready      (or_in_ready),
        .in_data       (sel_data),
        .in_sof        (sel_sof & (word_cnt == '0)),
        .in_eof        (sel_eof | last_word),
        .out_valid     (m_axis_tvalid),
        .out_ready     (m_axis_tready),
        .out_data      (m_axis_tdata),
        .out_sof       (m_axis_sof),
        .out_eof       (m_axis_eof)
    );

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state       <= ST_IDLE;
            o_grant     <= CH0;
            rr_last     <= CH1;
            o_prbs_seed <= '0;
            word_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_RELOAD;
                        o_grant     <= pick;
                        o_prbs_seed <= pick ? i_seed1 : i_seed0;
                        word_cnt    <= '0;
                    end
                end
                ST_RELOAD: state <= ST_XFER;
                ST_XFER: begin
                    if (xfer_fire) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (sel_eof) begin
                            state <= ST_DRAIN;
                        end else if (last_word) begin
                            state <= ST_FLUSH;
                        end
                        if (frame_done) begin
                            rr_last <= o_grant;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_end) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (out_empty) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky flags: a set condition in the same cycle as a clear takes priority.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            o_frame_cnt0  <= '0;
            o_frame_cnt1  <= '0;
            o_err_orphan  <= 1'b0;
            o_err_overlen <= 1'b0;
        end else begin
            if (frame_done && (o_grant == CH0)) begin
                o_frame_cnt0 <= o_frame_cnt0 + 1'b1;
            end
            if (frame_done && (o_grant == CH1)) begin
                o_frame_cnt1 <= o_frame_cnt1 + 1'b1;
            end
            o_err_orphan  <= orph0 | orph1 | (o_err_orphan & ~i_err_clr);
            o_err_overlen <= overlen_hit | (o_err_overlen & ~i_err_clr);
        end
    end

endmodule

// File: tb/tb_rx_frame_sched.sv
// Directed and randomized frames on both channels, checked against a frame-level
// model of round-robin scheduling, truncation and sticky error behaviour.
module tb_rx_frame_sched;

    localparam int DW   = 32;
    localparam int MAXL = 8;
    localparam int LW   = 16;

    logic          s_axi_aclk = 1'b0;
    logic          s_axi_aresetn = 1'b1;
    logic          i_enable = 1'b0;
    logic [31:0]   i_seed0 = '0, i_seed1 = '0;
    logic          i_err_clr = 1'b0;
    logic          s0_axis_tvalid = 1'b0, s0_axis_sof = 1'b0, s0_axis_eof = 1'b0;
    logic [DW-1:0] s0_axis_tdata = '0;
    logic          s1_axis_tvalid = 1'b0, s1_axis_sof = 1'b0, s1_axis_eof = 1'b0;
    logic [DW-1:0] s1_axis_tdata = '0;
    logic          s0_axis_tready, s1_axis_tready;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tvalid, m_axis_sof, m_axis_eof;
    logic [DW-1:0] m_axis_tdata;
    logic [31:0]   o_prbs_seed;
    logic          o_prbs_reload, o_grant, o_busy, o_err_orphan, o_err_overlen;
    logic [LW-1:0] o_frame_cnt0, o_frame_cnt1;

    always #5 s_axi_aclk = ~s_axi_aclk;

    rx_frame_sched #(
        .C_DATA_WIDTH    (DW),
        .C_MAX_FRAME_LEN (MAXL),
        .C_LEN_WIDTH     (LW)
    ) dut (
        .s_axi_aclk     (s_axi_aclk),
        .s_axi_aresetn  (s_axi_aresetn),
        .i_enable       (i_enable),
        .i_seed0        (i_seed0),
        .i_seed1        (i_seed1),
        .i_err_clr      (i_err_clr),
        .s0_axis_tvalid (s0_axis_tvalid),
        .s0_axis_tready (s0_axis_tready),
        .s0_axis_sof    (s0_axis_sof),
        .s0_axis_eof    (s0_axis_eof),
        .s0_axis_tdata  (s0_axis_tdata),
        .s1_axis_tvalid (s1_axis_tvalid),
        .s1_axis_tready (s1_axis_tready),
        .s1_axis_sof    (s1_axis_sof),
        .s1_axis_eof    (s1_axis_eof),
        .s1_axis_tdata  (s1_axis_tdata),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_sof     (m_axis_sof),
        .m_axis_eof     (m_axis_eof),
        .o_prbs_seed    (o_prbs_seed),
        .o_prbs_reload  (o_prbs_reload),
        .o_grant        (o_grant),
        .o_busy         (o_busy),
        .o_frame_cnt0   (o_frame_cnt0),
        .o_frame_cnt1   (o_frame_cnt1),
        .o_err_orphan   (o_err_orphan),
        .o_err_overlen  (o_err_overlen)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        sof;
        logic        eof;
    } word_t;

    typedef struct {
        int              len;
        logic [15:0][31:0] d;
    } frame_t;

    word_t       src0[$], src1[$], out_q[$], exp_q[$];
    logic [31:0] rseed_q[$], eseed_q[$];
    logic        rgnt_q[$], egnt_q[$];
    int          acc_cyc[$], out_cyc[$];
    frame_t      fq0[$], fq1[$];
    int          cyc = 0;
    int          rdy_mode = 0;
    int          m_last = 1;
    int unsigned m_cnt0 = 0, m_cnt1 = 0;
    logic        m_ovl = 1'b0, m_orph = 1'b0;
    int          checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive heads at the falling edge, sample handshakes just before the rising edge.
    task automatic tick();
        word_t h0, h1;
        logic  f0, f1;
        h0 = '0;
        h1 = '0;
        if (src0.size() != 0) h0 = src0[0];
        if (src1.size() != 0) h1 = src1[0];
        s0_axis_tvalid = (src0.size() != 0);
        s0_axis_tdata  = h0.d;
        s0_axis_sof    = h0.sof;
        s0_axis_eof    = h0.eof;
        s1_axis_tvalid = (src1.size() != 0);
        s1_axis_tdata  = h1.d;
        s1_axis_sof    = h1.sof;
        s1_axis_eof    = h1.eof;
        case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: m_axis_tready = ($urandom_range(0, 99) < 65);
        endcase
        #4;
        f0 = s0_axis_tvalid && s0_axis_tready;
        f1 = s1_axis_tvalid && s1_axis_tready;
        if (m_axis_tvalid && m_axis_tready) begin
            out_q.push_back('{d: m_axis_tdata, sof: m_axis_sof, eof: m_axis_eof});
            out_cyc.push_back(cyc);
        end
        if (o_prbs_reload) begin
            rseed_q.push_back(o_prbs_seed);
            rgnt_q.push_back(o_grant);
            chk("reload_out_empty", 64'(m_axis_tvalid), 64'(0));
            chk("reload_tready", 64'({s0_axis_tready, s1_axis_tready}), 64'(0));
        end
        if (f0) begin
            void'(src0.pop_front());
            acc_cyc.push_back(cyc);
        end
        if (f1) begin
            void'(src1.pop_front());
            acc_cyc.push_back(cyc);
        end
        @(posedge s_axi_aclk);
        @(negedge s_axi_aclk);
        cyc++;
    endtask

    task automatic add_frame(input int ch, input int len, input logic [31:0] base, input bit rnd);
        frame_t f;
        word_t  w;
        f.len = len;
        f.d   = '0;
        for (int i = 0; i < len; i++) begin
            f.d[i] = rnd ? $urandom : 32'(base * 32'(i + 1));
            w.d    = f.d[i];
            w.sof  = (i == 0) || (rnd && ($urandom_range(0, 3) == 0));
            w.eof  = (i == len - 1);
            if (ch == 0) src0.push_back(w);
            else         src1.push_back(w);
        end
        if (ch == 0) fq0.push_back(f);
        else         fq1.push_back(f);
    endtask

    // Frame-level model: alternate on ties, truncate at MAXL with eof forced, count frames.
    task automatic model_sched();
        frame_t f;
        int     ch, n;
        while (fq0.size() != 0 || fq1.size() != 0) begin
            if (fq0.size() != 0 && fq1.size() != 0) ch = 1 - m_last;
            else ch = (fq0.size() != 0) ? 0 : 1;
            if (ch == 1) f = fq1.pop_front();
            else         f = fq0.pop_front();
            egnt_q.push_back(ch[0]);
            eseed_q.push_back((ch == 1) ? i_seed1 : i_seed0);
            n = (f.len > MAXL) ? MAXL : f.len;
            for (int i = 0; i < n; i++)
                exp_q.push_back('{d: f.d[i], sof: (i == 0), eof: (i == n - 1)});
            if (f.len > MAXL) m_ovl = 1'b1;
            if (ch == 1) m_cnt1++;
            else         m_cnt0++;
            m_last = ch;
        end
    endtask

    task automatic run_done(input string tag, input int budget);
        int n;
        n = 0;
        while ((src0.size() != 0 || src1.size() != 0 || o_busy || m_axis_tvalid) && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 64'(n < budget), 64'(1));
    endtask

    task automatic compare(input string tag);
        chk({tag, "_nwords"}, 64'(out_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_word%0d", tag, i), 64'(out_q[i]), 64'(exp_q[i]));
        chk({tag, "_nreload"}, 64'(rgnt_q.size()), 64'(egnt_q.size()));
        for (int i = 0; i < rgnt_q.size() && i < egnt_q.size(); i++) begin
            chk($sformatf("%s_grant%0d", tag, i), 64'(rgnt_q[i]), 64'(egnt_q[i]));
            chk($sformatf("%s_seed%0d", tag, i), 64'(rseed_q[i]), 64'(eseed_q[i]));
        end
        chk({tag, "_cnt0"}, 64'(o_frame_cnt0), 64'(m_cnt0[LW-1:0]));
        chk({tag, "_cnt1"}, 64'(o_frame_cnt1), 64'(m_cnt1[LW-1:0]));
        chk({tag, "_overlen"}, 64'(o_err_overlen), 64'(m_ovl));
        chk({tag, "_orphan"}, 64'(o_err_orphan), 64'(m_orph));
        out_q.delete(); exp_q.delete(); rgnt_q.delete(); egnt_q.delete();
        rseed_q.delete(); eseed_q.delete(); acc_cyc.delete(); out_cyc.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_s0_tready"}, 64'(s0_axis_tready), 64'(0));
        chk({tag, "_s1_tready"}, 64'(s1_axis_tready), 64'(0));
        chk({tag, "_m_tvalid"}, 64'(m_axis_tvalid), 64'(0));
        chk({tag, "_m_tdata"}, 64'(m_axis_tdata), 64'(0));
        chk({tag, "_m_framing"}, 64'({m_axis_sof, m_axis_eof}), 64'(0));
        chk({tag, "_seed"}, 64'(o_prbs_seed), 64'(0));
        chk({tag, "_reload"}, 64'(o_prbs_reload), 64'(0));
        chk({tag, "_grant"}, 64'(o_grant), 64'(0));
        chk({tag, "_busy"}, 64'(o_busy), 64'(0));
        chk({tag, "_cnt0"}, 64'(o_frame_cnt0), 64'(0));
        chk({tag, "_cnt1"}, 64'(o_frame_cnt1), 64'(0));
        chk({tag, "_errs"}, 64'({o_err_orphan, o_err_overlen}), 64'(0));
    endtask

    task automatic clear_errs();
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        m_ovl  = 1'b0;
        m_orph = 1'b0;
        chk("err_clr", 64'({o_err_orphan, o_err_overlen}), 64'(0));
    endtask

    initial begin
        int n;
        i_seed0 = 32'hDEADBEEF;
        i_seed1 = 32'hC0FFEE01;
        #2 s_axi_aresetn = 1'b0;
        @(negedge s_axi_aclk);
        check_all_zero("reset");
        @(negedge s_axi_aclk);
        s_axi_aresetn = 1'b1;
        i_enable = 1'b1;

        // Both channels with back-to-back 3-word frames: grants alternate from ch0.
        for (int k = 0; k < 2; k++) begin
            add_frame(0, 3, 32'h0A00 + 32'(k * 16), 1'b0);
            add_frame(1, 3, 32'h0B00 + 32'(k * 16), 1'b0);
        end
        model_sched();
        run_done("alt", 200);
        compare("alt");

        // Single 4-word frame on ch0, output one cycle after acceptance.
        add_frame(0, 4, 32'h11, 1'b0);
        model_sched();
        run_done("single", 100);
        chk("single_nacc", 64'(acc_cyc.size()), 64'(4));
        for (int i = 0; i < acc_cyc.size() && i < out_cyc.size(); i++)
            chk($sformatf("single_lat%0d", i), 64'(out_cyc[i]), 64'(acc_cyc[i] + 1));
        compare("single");

        // Output back-pressure 1-0-0-1 during a 6-word frame.
        rdy_mode = 1;
        add_frame(0, 6, 32'h1234, 1'b0);
        model_sched();
        run_done("bp", 200);
        compare("bp");
        rdy_mode = 0;

        // Scheduler disabled: nothing is accepted.
        i_enable = 1'b0;
        add_frame(1, 3, 32'h5500, 1'b0);
        repeat (3) tick();
        chk("dis_tready", 64'(s1_axis_tready), 64'(0));
        chk("dis_pending", 64'(src1.size()), 64'(3));
        chk("dis_busy", 64'(o_busy), 64'(0));
        i_enable = 1'b1;
        model_sched();
        run_done("dis", 100);
        compare("dis");

        // Over-length frame on ch1, then a normal frame.
        add_frame(1, MAXL + 3, 32'h7700, 1'b0);
        add_frame(1, 3, 32'h8800, 1'b0);
        model_sched();
        run_done("ovl", 300);
        compare("ovl");
        clear_errs();

        // Orphan word while idle, then a normal frame.
        src0.push_back('{d: 32'h0BAD, sof: 1'b0, eof: 1'b0});
        repeat (3) tick();
        chk("orph_consumed", 64'(src0.size()), 64'(0));
        chk("orph_no_out", 64'(out_q.size()), 64'(0));
        chk("orph_flag", 64'(o_err_orphan), 64'(1));
        m_orph = 1'b1;
        add_frame(0, 2, 32'h9900, 1'b0);
        model_sched();
        run_done("orph", 100);
        compare("orph");
        clear_errs();

        // Randomized frames, lengths and back-pressure.
        rdy_mode = 2;
        for (int k = 0; k < 14; k++)
            add_frame(int'($urandom_range(0, 1)), int'($urandom_range(1, MAXL + 3)), 32'h0, 1'b1);
        model_sched();
        run_done("rnd", 4000);
        compare("rnd");
        clear_errs();
        rdy_mode = 0;

        // Asynchronous reset while word 2 of a frame is in flight.
        for (int i = 0; i < 6; i++)
            src0.push_back('{d: 32'hE000 + 32'(i), sof: (i == 0), eof: (i == 5)});
        n = 0;
        while (acc_cyc.size() < 2 && n < 50) begin
            tick();
            n++;
        end
        chk("rst_mid_reach", 64'(n < 50), 64'(1));
        #2 s_axi_aresetn = 1'b0;
        #1 check_all_zero("rst_mid");
        src0.delete(); src1.delete();
        s0_axis_tvalid = 1'b0;
        s1_axis_tvalid = 1'b0;
        out_q.delete(); rgnt_q.delete(); rseed_q.delete(); acc_cyc.delete(); out_cyc.delete();
        m_last = 1; m_cnt0 = 0; m_cnt1 = 0; m_ovl = 1'b0; m_orph = 1'b0;
        @(negedge s_axi_aclk);
        s_axi_aresetn = 1'b1;
        add_frame(1, 2, 32'hF100, 1'b0);
        add_frame(0, 2, 32'hF000, 1'b0);
        model_sched();
        run_done("post_rst", 100);
        compare("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
